// File: rtl/fb_pixel_writer.sv
// Pixel-stream consumer: clips incoming pixels, converts them to linear framebuffer
// addresses and writes them; also owns the clear-screen fill sequencer.
module fb_pixel_writer #(
    parameter int unsigned XY_BITW   = 16,
    parameter int unsigned FB_WIDTH  = 320,
    parameter int unsigned FB_HEIGHT = 240,
    parameter int unsigned ADDR_BITW = 17,
    parameter int unsigned COLR_BITW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 px_valid,
    input  logic [XY_BITW-1:0]   px_x,
    input  logic [XY_BITW-1:0]   px_y,
    input  logic [COLR_BITW-1:0] px_colr,
    output logic                 px_ready,
    input  logic                 clear,
    input  logic [COLR_BITW-1:0] clear_colr,
    output logic                 fb_we,
    output logic [ADDR_BITW-1:0] fb_addr,
    output logic [COLR_BITW-1:0] fb_data,
    output logic                 busy,
    output logic                 clear_done,
    output logic [15:0]          clip_count
);

    localparam int unsigned PIX_N  = FB_WIDTH * FB_HEIGHT;
    // One extra bit so the fill counter can reach PIX_N even when PIX_N == 2**ADDR_BITW
    localparam int unsigned CNT_W  = ADDR_BITW + 1;
    localparam int unsigned WIDE_W = XY_BITW + 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_nxt;

    logic                 s1_valid;
    logic                 s1_inb;
    logic [XY_BITW-1:0]   s1_x;
    logic [XY_BITW-1:0]   s1_y;
    logic [COLR_BITW-1:0] s1_colr;

    logic [CNT_W-1:0]     clr_cnt;
    logic [CNT_W-1:0]     clr_cnt_nxt;
    logic [COLR_BITW-1:0] clr_colr_q;
    logic [COLR_BITW-1:0] clr_colr_nxt;

    logic                 we_nxt;
    logic [ADDR_BITW-1:0] addr_nxt;
    logic [COLR_BITW-1:0] data_nxt;
    logic                 done_nxt;

    logic                 px_acc_c;
    logic                 px_inb_c;

    assign px_acc_c = px_valid && px_ready;
    assign px_inb_c = (WIDE_W'(px_x) < WIDE_W'(FB_WIDTH)) && (WIDE_W'(px_y) < WIDE_W'(FB_HEIGHT));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next framebuffer port value; pixel and clear writes are exclusive
    always_comb begin
        state_nxt    = state;
        clr_cnt_nxt  = clr_cnt;
        clr_colr_nxt = clr_colr_q;
        we_nxt       = 1'b0;
        addr_nxt     = fb_addr;
        data_nxt     = fb_data;
        done_nxt     = 1'b0;

        if (s1_valid && s1_inb) begin
            we_nxt   = 1'b1;
            addr_nxt = ADDR_BITW'(WIDE_W'(s1_y) * WIDE_W'(FB_WIDTH) + WIDE_W'(s1_x));
            data_nxt = s1_colr;
        end

        case (state)
            ST_IDLE: begin
                if (clear) begin
                    clr_colr_nxt = clear_colr;
                    state_nxt    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid) begin
                    state_nxt   = ST_CLEAR;
                    we_nxt      = 1'b1;
                    addr_nxt    = '0;
                    data_nxt    = clr_colr_q;
                    clr_cnt_nxt = CNT_W'(1);
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == CNT_W'(PIX_N)) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    we_nxt      = 1'b1;
                    addr_nxt    = ADDR_BITW'(clr_cnt);
                    data_nxt    = clr_colr_q;
                    clr_cnt_nxt = clr_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs and clear sequencer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_ready   <= 1'b1;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            clr_cnt    <= '0;
            clr_colr_q <= '0;
        end else begin
            px_ready   <= (state_nxt == ST_IDLE);
            busy       <= (state_nxt != ST_IDLE);
            clear_done <= done_nxt;
            fb_we      <= we_nxt;
            fb_addr    <= addr_nxt;
            fb_data    <= data_nxt;
            clr_cnt    <= clr_cnt_nxt;
            clr_colr_q <= clr_colr_nxt;
        end
    end

    // Pipeline stage 1: capture accepted pixel and its clip decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_inb   <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_colr  <= '0;
        end else begin
            s1_valid <= px_acc_c;
            if (px_acc_c) begin
                s1_inb  <= px_inb_c;
                s1_x    <= px_x;
                s1_y    <= px_y;
                s1_colr <= px_colr;
            end
        end
    end

    // Saturating count of clipped pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_count <= '0;
        end else if (px_acc_c && !px_inb_c && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: a full-size instance for the pixel path and an 8x4 instance
// for clear-screen behaviour, both checked cycle by cycle against a write-schedule model.
module tb_fb_pixel_writer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        b_valid, b_ready, b_clear, b_we, b_busy, b_done;
    logic [15:0] b_x, b_y, b_clip;
    logic [3:0]  b_colr, b_clear_colr, b_data;
    logic [16:0] b_addr;

    logic        s_valid, s_ready, s_clear, s_we, s_busy, s_done;
    logic [15:0] s_x, s_y, s_clip;
    logic [3:0]  s_colr, s_clear_colr, s_data;
    logic [4:0]  s_addr;

    fb_pixel_writer u_big (
        .clk(clk), .rst(rst), .px_valid(b_valid), .px_x(b_x), .px_y(b_y), .px_colr(b_colr),
        .px_ready(b_ready), .clear(b_clear), .clear_colr(b_clear_colr), .fb_we(b_we),
        .fb_addr(b_addr), .fb_data(b_data), .busy(b_busy), .clear_done(b_done), .clip_count(b_clip)
    );

    fb_pixel_writer #(.FB_WIDTH(8), .FB_HEIGHT(4), .ADDR_BITW(5)) u_small (
        .clk(clk), .rst(rst), .px_valid(s_valid), .px_x(s_x), .px_y(s_y), .px_colr(s_colr),
        .px_ready(s_ready), .clear(s_clear), .clear_colr(s_clear_colr), .fb_we(s_we),
        .fb_addr(s_addr), .fb_data(s_data), .busy(s_busy), .clear_done(s_done), .clip_count(s_clip)
    );

    int cyc, checks, errors;
    int clip_b, clip_s, blk_lo, blk_hi;
    bit acc_b, acc_s;
    logic [31:0] exp_addr_b[int];
    logic [31:0] exp_data_b[int];
    logic [31:0] exp_addr_s[int];
    logic [31:0] exp_data_s[int];
    bit          exp_done_s[int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic bit sm_ready_at(input int c);
        return !(c >= blk_lo && c <= blk_hi);
    endfunction

    task automatic check_all();
        bit want;
        bit rdy;
        want = exp_addr_b.exists(cyc);
        chk("big_we", 32'(b_we), 32'(want));
        if (want) begin
            chk("big_addr", 32'(b_addr), exp_addr_b[cyc]);
            chk("big_data", 32'(b_data), exp_data_b[cyc]);
        end
        chk("big_ready", 32'(b_ready), 32'd1);
        chk("big_busy", 32'(b_busy), 32'd0);
        chk("big_clip", 32'(b_clip), 32'(clip_b));

        want = exp_addr_s.exists(cyc);
        rdy  = sm_ready_at(cyc);
        chk("sm_we", 32'(s_we), 32'(want));
        if (want) begin
            chk("sm_addr", 32'(s_addr), exp_addr_s[cyc]);
            chk("sm_data", 32'(s_data), exp_data_s[cyc]);
        end
        chk("sm_ready", 32'(s_ready), 32'(rdy));
        chk("sm_busy", 32'(s_busy), 32'(!rdy));
        chk("sm_done", 32'(s_done), 32'(exp_done_s.exists(cyc)));
        chk("sm_clip", 32'(s_clip), 32'(clip_s));
    endtask

    // Model of what the current inputs cause, from the acceptance and clear rules
    task automatic model_accept();
        int f;
        acc_b = 1'b0;
        acc_s = 1'b0;
        if (rst) return;
        if (b_valid) begin
            acc_b = 1'b1;
            if (32'(b_x) < 32'd320 && 32'(b_y) < 32'd240) begin
                exp_addr_b[cyc+2] = 32'(b_y) * 32'd320 + 32'(b_x);
                exp_data_b[cyc+2] = 32'(b_colr);
            end else if (clip_b < 65535) begin
                clip_b++;
            end
        end
        if (sm_ready_at(cyc)) begin
            if (s_valid) begin
                acc_s = 1'b1;
                if (32'(s_x) < 32'd8 && 32'(s_y) < 32'd4) begin
                    exp_addr_s[cyc+2] = 32'(s_y) * 32'd8 + 32'(s_x);
                    exp_data_s[cyc+2] = 32'(s_colr);
                end else if (clip_s < 65535) begin
                    clip_s++;
                end
            end
            if (s_clear) begin
                f = cyc + 2 + int'(acc_s);
                for (int i = 0; i < 32; i++) begin
                    exp_addr_s[f+i] = 32'(i);
                    exp_data_s[f+i] = 32'(s_clear_colr);
                end
                exp_done_s[f+32] = 1'b1;
                blk_lo = cyc + 1;
                blk_hi = f + 31;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_all();
    endtask

    task automatic step();
        model_accept();
        tick();
    endtask

    task automatic rand_big();
        b_valid = ($urandom % 4) != 0;
        b_x     = (($urandom % 10) == 0) ? 16'hFFFF : 16'($urandom_range(0, 340));
        b_y     = 16'($urandom_range(0, 260));
        b_colr  = 4'($urandom);
    endtask

    task automatic rand_small();
        if (!s_valid || acc_s) begin
            s_valid = ($urandom % 2) != 0;
            s_x     = 16'($urandom_range(0, 10));
            s_y     = 16'($urandom_range(0, 5));
            s_colr  = 4'($urandom);
        end
        s_clear      = ($urandom % 30) == 0;
        s_clear_colr = 4'($urandom);
    endtask

    task automatic reset_now();
        rst = 1'b1;
        #1;
        chk("rst_big_we", 32'(b_we), 32'd0);
        chk("rst_sm_we", 32'(s_we), 32'd0);
        chk("rst_big_clip", 32'(b_clip), 32'd0);
        chk("rst_sm_ready", 32'(s_ready), 32'd1);
        chk("rst_sm_busy", 32'(s_busy), 32'd0);
        exp_addr_b.delete();
        exp_data_b.delete();
        exp_addr_s.delete();
        exp_data_s.delete();
        exp_done_s.delete();
        clip_b = 0;
        clip_s = 0;
        blk_lo = 1;
        blk_hi = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int bx[4] = '{0, 1, 2, 0};
    int by[4] = '{0, 0, 0, 1};
    int cx[4] = '{320, 0, 65535, 319};
    int cy[4] = '{0, 240, 65535, 239};
    int t0;

    initial begin
        rst = 1'b1;
        cyc = 0; checks = 0; errors = 0;
        clip_b = 0; clip_s = 0; blk_lo = 1; blk_hi = 0;
        acc_b = 1'b0; acc_s = 1'b0;
        b_valid = 0; b_x = 0; b_y = 0; b_colr = 0; b_clear = 0; b_clear_colr = 0;
        s_valid = 0; s_x = 0; s_y = 0; s_colr = 0; s_clear = 0; s_clear_colr = 0;
        tick();
        tick();
        rst = 1'b0;

        // Single pixel (5,3) -> address 965
        b_valid = 1; b_x = 5; b_y = 3; b_colr = 4'hA;
        step();
        b_valid = 0;
        repeat (3) step();

        // Four-pixel back-to-back stream
        for (int i = 0; i < 4; i++) begin
            b_valid = 1; b_x = 16'(bx[i]); b_y = 16'(by[i]); b_colr = 4'(i + 1);
            step();
        end
        b_valid = 0;
        repeat (3) step();

        // Clipping boundaries, then the last in-bounds pixel
        for (int i = 0; i < 4; i++) begin
            b_valid = 1; b_x = 16'(cx[i]); b_y = 16'(cy[i]); b_colr = 4'h6;
            step();
        end
        b_valid = 0;
        repeat (3) step();
        chk("big_clip_three", 32'(b_clip), 32'd3);

        // Pixel and clear in the same cycle, then a pixel held while busy
        s_valid = 1; s_x = 1; s_y = 1; s_colr = 4'h3; s_clear = 1; s_clear_colr = 4'h7;
        step();
        s_clear = 0;
        s_x = 2; s_y = 2; s_colr = 4'h5;
        for (int i = 0; i < 40; i++) begin
            s_clear = (i == 10);
            step();
            if (acc_s) s_valid = 0;
        end
        s_clear = 0;
        s_valid = 0;
        repeat (3) step();

        // Randomized traffic on both instances, including clears on the small one
        for (int i = 0; i < 400; i++) begin
            rand_big();
            rand_small();
            step();
        end
        s_valid = 0; s_clear = 0;
        for (int i = 0; i < 40 && !sm_ready_at(cyc); i++) begin
            rand_big();
            step();
        end

        // Reset after ten clear writes while the big instance streams
        s_clear = 1; s_clear_colr = 4'hC;
        t0 = cyc;
        rand_big();
        step();
        s_clear = 0;
        for (int i = 0; i < 40 && cyc < t0 + 11; i++) begin
            rand_big();
            step();
        end
        reset_now();
        b_valid = 0;
        repeat (5) step();
        s_valid = 1; s_x = 2; s_y = 2; s_colr = 4'h9;
        step();
        s_valid = 0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Consumer side of the line-drawing pixel stream. Accepts (x, y, colour) pixels from the line drawer, clips them to the framebuffer, converts them to linear addresses and issues single-cycle writes to the framebuffer memory port. Also owns a clear-screen sequencer that fills the whole framebuffer with one colour between frames, stalling the pixel stream while it runs.

## Interface
- XY_BITW, 16, bit width of incoming x/y coordinates
- FB_WIDTH, 320, framebuffer width in pixels
- FB_HEIGHT, 240, framebuffer height in pixels
- ADDR_BITW, 17, framebuffer address width; 2^ADDR_BITW >= FB_WIDTH*FB_HEIGHT
- COLR_BITW, 4, pixel colour width

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- px_valid  in  1  pixel present on px_x/px_y/px_colr
- px_x  in  XY_BITW  pixel horizontal position, unsigned
- px_y  in  XY_BITW  pixel vertical position, unsigned
- px_colr  in  COLR_BITW  pixel colour
- px_ready  out  1  pixel accepted when px_valid && px_ready
- clear  in  1  request clear-screen (sampled only in IDLE)
- clear_colr  in  COLR_BITW  fill colour, sampled with clear
- fb_we  out  1  framebuffer write strobe
- fb_addr  out  ADDR_BITW  framebuffer write address
- fb_data  out  COLR_BITW  framebuffer write data
- busy  out  1  state != IDLE
- clear_done  out  1  one-cycle pulse after last clear write
- clip_count  out  16  count of accepted pixels dropped by clipping

## Operation
- States: IDLE, DRAIN, CLEAR. px_ready = 1 only in IDLE (registered, tracks state).
- Pixel pipeline, 2 stages. S1: register x, y, colour, valid; compute in_bounds = (x < FB_WIDTH) && (y < FB_HEIGHT). S2: addr = y*FB_WIDTH + x, product at full width then truncated to ADDR_BITW; drive fb_we/fb_addr/fb_data registered.
- Out-of-bounds pixels: no write; clip_count += 1, saturating at 0xFFFF; cleared only by rst.
- IDLE: clear=1 → latch clear_colr, go DRAIN. A pixel presented in the same cycle as clear is accepted (px_ready was high).
- DRAIN: stay until S1 holds no valid pixel, then go CLEAR. In-flight pixel writes always complete before any clear write.
- CLEAR: one write per cycle, fb_addr = 0,1,…,FB_WIDTH*FB_HEIGHT-1, fb_data = latched clear_colr. After last address → IDLE, clear_done pulses.
- clear asserted in DRAIN/CLEAR ignored. px_valid while px_ready=0: not accepted, inputs must be held by source.
- fb port has a single owner per cycle; pixel and clear writes never coincide.

## Timing
- Reset: state IDLE, px_ready=1, fb_we=0, fb_addr=0, fb_data=0, busy=0, clear_done=0, clip_count=0, pipeline valids 0.
- Pixel accepted cycle T → fb_we=1 at T+2 with its addr/data (in-bounds). Full throughput, one pixel/cycle, order preserved.
- clear sampled at T: px_ready=0 and busy=1 from T+1.
- First clear write (addr 0) at T+2 if no pixel accepted at T; at T+3 if a pixel was accepted at T (its write occupies T+2).
- Last clear write at first-clear-cycle + N-1, N = FB_WIDTH*FB_HEIGHT. Next cycle: clear_done=1 (one cycle), px_ready=1, busy=0, fb_we=0.
- Clip decision and counter update take effect at T+1 after acceptance.
- Reset mid-operation: immediate fb_we=0, clear aborted, pipeline flushed, outputs at reset values; no resumption.

## Test plan
- Reset: assert rst mid-stream → all outputs at reset values, px_ready=1, clip_count=0.
- Single pixel, default params: (5,3,0xA) accepted at T → fb_we at T+2, fb_addr=965, fb_data=0xA; fb_we=0 at T+3.
- Stream: 4 pixels (0,0),(1,0),(2,0),(0,1) on consecutive cycles → fb_we high 4 consecutive cycles, addrs 0,1,2,320 in order.
- Clipping: (320,0), (0,240), (0xFFFF,0xFFFF) → no writes, clip_count=3; (319,239) → addr 76799.
- Clear collision, FB_WIDTH=8, FB_HEIGHT=4, ADDR_BITW=5: pixel (1,1,0x3) and clear with clear_colr=0x7 at T → write addr 9 data 0x3 at T+2; clear writes addr 0..31 data 0x7 at T+3..T+34; clear_done at T+35 with px_ready=1; px_valid held during T+1..T+34 not accepted.
- Reset mid-clear (small params): rst after 10 clear writes → fb_we=0 during reset; after release, no further clear writes, pixel (2,2) written to addr 18 two cycles after acceptance.
